// File: rtl/seq_adder_pkg.sv
// rtl/seq_adder_pkg.sv - shared state encoding and sizing helper for the sequential adder
package seq_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Slice counter width; a single-slice adder still needs one counter bit.
   function automatic int cnt_width(input int nchunk);
      return (nchunk > 1) ? $clog2(nchunk) : 1;
   endfunction

endpackage

// File: rtl/seq_adder64_chunk_adder.sv
// rtl/seq_adder64_chunk_adder.sv - combinational CHUNK-bit slice adder with carry in/out
module chunk_adder #(
   parameter int CHUNK = 16
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout
);

   assign {cout, s} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/seq_adder64.sv
// rtl/seq_adder64.sv - multi-cycle WIDTH-bit adder, one CHUNK slice per clock, valid/ready on both sides
module seq_adder64
   import seq_adder_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW = cnt_width(NCHUNK);
   localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

   state_t           state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] sum_q;
   logic             c_q;
   logic             carry_q;
   logic             ovf_q;
   logic [CW-1:0]    cnt;

   logic [CHUNK-1:0] x;
   logic [CHUNK-1:0] y;
   logic [CHUNK-1:0] s;
   logic             cout;

   // Slice mux feeding the single shared slice adder.
   always_comb begin
      x = '0;
      y = '0;
      for (int i = 0; i < NCHUNK; i++) begin
         if (cnt == CW'(i)) begin
            x = a_q[i*CHUNK +: CHUNK];
            y = b_q[i*CHUNK +: CHUNK];
         end
      end
   end

   chunk_adder #(.CHUNK(CHUNK)) u_chunk (
      .x    (x),
      .y    (y),
      .cin  (c_q),
      .s    (s),
      .cout (cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         c_q     <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q   <= a;
                  b_q   <= b;
                  c_q   <= 1'b0;
                  cnt   <= '0;
                  state <= BUSY;
               end
            end
            BUSY: begin
               for (int i = 0; i < NCHUNK; i++) begin
                  if (cnt == CW'(i)) begin
                     sum_q[i*CHUNK +: CHUNK] <= s;
                  end
               end
               c_q <= cout;
               cnt <= cnt + 1'b1;
               // Last slice: the top bit of s is the result sign bit.
               if (cnt == LAST) begin
                  carry_q <= cout;
                  ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s[CHUNK-1] != a_q[WIDTH-1]);
                  cnt     <= '0;
                  state   <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign sum       = sum_q;
   assign carry     = carry_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_seq_adder64.sv
// tb/tb_seq_adder64.sv - scoreboard bench for seq_adder64
module tb_seq_adder64;

   typedef struct packed {
      logic [63:0] s;
      logic        c;
      logic        v;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] a;
   logic [63:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] sum;
   logic        carry;
   logic        overflow;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sb[$];

   seq_adder64 #(.WIDTH(64), .CHUNK(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry     (carry),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_tests++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic exp_t model(input logic [63:0] x, input logic [63:0] y);
      exp_t       e;
      logic [64:0] full;
      full = {1'b0, x} + {1'b0, y};
      e.s = full[63:0];
      e.c = full[64];
      e.v = (x[63] == y[63]) && (full[63] != x[63]);
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one operand pair, push the expected result, return cycles until out_valid.
   task automatic send(input logic [63:0] x, input logic [63:0] y, output int lat);
      int guard;
      guard = 0;
      while (!in_ready && guard < 20) begin
         tick();
         guard++;
      end
      chk("accept_ready", {63'd0, in_ready}, 64'd1);
      a = x;
      b = y;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      a = $urandom();
      b = $urandom();
      sb.push_back(model(x, y));
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   task automatic receive(input string tag);
      exp_t e;
      chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 64'd0, 64'd1);
      end else begin
         e = sb.pop_front();
         chk({tag, "_sum"}, sum, e.s);
         chk({tag, "_carry"}, {63'd0, carry}, {63'd0, e.c});
         chk({tag, "_ovf"}, {63'd0, overflow}, {63'd0, e.v});
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      int   lat;
      exp_t e;
      logic [63:0] ra;
      logic [63:0] rb;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      tick();
      tick();
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_sum", sum, 64'd0);
      chk("rst_carry", {63'd0, carry}, 64'd0);
      chk("rst_ovf", {63'd0, overflow}, 64'd0);
      rst_n = 1'b1;
      tick();

      send(64'hA, 64'h5, lat);
      chk("latency", 64'(lat), 64'd4);
      receive("small");

      send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, lat);
      receive("ripple");

      send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, lat);
      receive("sovf");

      send(64'h1234_5678_90AB_CDEF, 64'hEDCB_A987_6F54_3211, lat);
      receive("negate");

      send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, lat);
      receive("novf");

      for (int i = 0; i < 8; i++) begin
         ra = {$urandom(), $urandom()};
         rb = {$urandom(), $urandom()};
         send(ra, rb, lat);
         chk("rand_latency", 64'(lat), 64'd4);
         receive("rand");
      end

      // Backpressure: result held in DONE while new operands are offered.
      send(64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, lat);
      e = sb[0];
      for (int i = 0; i < 5; i++) begin
         a = {$urandom(), $urandom()};
         b = {$urandom(), $urandom()};
         in_valid = 1'b1;
         tick();
         chk("bp_sum", sum, e.s);
         chk("bp_carry", {63'd0, carry}, {63'd0, e.c});
         chk("bp_ovf", {63'd0, overflow}, {63'd0, e.v});
         chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
         chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
      end
      in_valid = 1'b0;
      receive("bp");
      chk("bp_ready_after", {63'd0, in_ready}, 64'd1);
      tick();
      tick();
      chk("bp_no_accept", {63'd0, out_valid}, 64'd0);
      chk("bp_idle", {63'd0, in_ready}, 64'd1);

      // Reset during the second BUSY cycle aborts the operation.
      a = 64'd5;
      b = 64'hA;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      tick();
      chk("abort_sum", sum, 64'd0);
      chk("abort_carry", {63'd0, carry}, 64'd0);
      chk("abort_ovf", {63'd0, overflow}, 64'd0);
      chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
      chk("abort_in_ready", {63'd0, in_ready}, 64'd1);

      send(64'd5, 64'hA, lat);
      chk("post_rst_latency", 64'(lat), 64'd4);
      receive("post_rst");
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
